// File: rtl/kiwi_tma_perf_counter.sv
// kiwi_tma_perf_counter: top-down microarchitecture analysis counters.
// Accumulates saturating raw slot counts from decode/retire/stall/flush
// strobes and produces a frozen snapshot of derived metrics through a
// snap_req / snap_vld / snap_ack handshake.
// Optional feature macro: KIWI_TMA_HALT_DETECT_EN (halt-instruction detect
// that freezes the raw counters once the halt encoding is decoded).
module kiwi_tma_perf_counter #(
  parameter int          DECODE_W      = 2,
  parameter int          RETIRE_W      = 2,
  parameter int          CNT_W         = 64,
  parameter int          FLUSH_PENALTY = 8,
  parameter logic [31:0] HALT_INST     = 32'h0000_006b
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_en,
  input  logic                  clear,
  input  logic [DECODE_W-1:0]   decode_vld,
  input  logic [32*DECODE_W-1:0] decode_inst,
  input  logic                  backend_stall,
  input  logic                  flush_pipe,
  input  logic [RETIRE_W-1:0]   retire_vld,
  input  logic                  snap_req,
  input  logic                  snap_ack,
  output logic                  snap_vld,
  output logic [CNT_W-1:0]      m_total,
  output logic [CNT_W-1:0]      m_retire,
  output logic [CNT_W-1:0]      m_bad_spec,
  output logic [CNT_W-1:0]      m_flush_rec,
  output logic [CNT_W-1:0]      m_frontend,
  output logic [CNT_W-1:0]      m_backend,
  output logic                  halted
);

  localparam int DPC_W = $clog2(DECODE_W + 1);
  localparam int RPC_W = $clog2(RETIRE_W + 1);
  localparam logic [DPC_W-1:0] DEC_FULL = DPC_W'(DECODE_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  function automatic logic [DPC_W-1:0] pop_dec(input logic [DECODE_W-1:0] v);
    logic [DPC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DECODE_W; i++) c = c + DPC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [RPC_W-1:0] pop_ret(input logic [RETIRE_W-1:0] v);
    logic [RPC_W-1:0] c;
    c = '0;
    for (int i = 0; i < RETIRE_W; i++) c = c + RPC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_mul_penalty(input logic [CNT_W-1:0] a);
    logic [CNT_W+31:0] p;
    p = {32'd0, a} * (CNT_W+32)'(FLUSH_PENALTY);
    return (|p[CNT_W+31:CNT_W]) ? '1 : p[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] floor_sub(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  logic [CNT_W-1:0] total_cnt, instr_cnt, retire_cnt;
  logic [CNT_W-1:0] bubble_cnt, backend_cnt, flush_cnt;
  logic [CNT_W-1:0] total_p0, instr_p0, retire_p0;
  logic [CNT_W-1:0] bubble_p0, backend_p0, flush_p0;
  logic [CNT_W-1:0] flush_rec_calc;
  logic [DPC_W-1:0] dec_slots;
  logic [RPC_W-1:0] ret_slots;
  logic             update;
  state_t           state;

  assign dec_slots      = pop_dec(decode_vld);
  assign ret_slots      = pop_ret(retire_vld);
  assign update         = cnt_en && !halted;
  assign flush_rec_calc = sat_mul_penalty(flush_p0);

`ifdef KIWI_TMA_HALT_DETECT_EN
  logic halt_hit;

  // Any valid decode slot carrying the halt encoding.
  always_comb begin
    halt_hit = 1'b0;
    for (int i = 0; i < DECODE_W; i++)
      if (decode_vld[i] && (decode_inst[32*i +: 32] == HALT_INST)) halt_hit = 1'b1;
  end

  // Sticky halt flag; only reset releases it.
  always_ff @(posedge clk) begin
    if (!rst_n)        halted <= 1'b0;
    else if (halt_hit) halted <= 1'b1;
  end
`else
  logic unused_decode_inst;
  assign unused_decode_inst = ^decode_inst;
  assign halted = 1'b0;
`endif

  // Raw saturating slot counters; clear wins over the increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      total_cnt   <= '0;
      instr_cnt   <= '0;
      retire_cnt  <= '0;
      bubble_cnt  <= '0;
      backend_cnt <= '0;
      flush_cnt   <= '0;
    end else if (update) begin
      total_cnt  <= sat_add(total_cnt, CNT_W'(DEC_FULL));
      instr_cnt  <= sat_add(instr_cnt, CNT_W'(dec_slots));
      retire_cnt <= sat_add(retire_cnt, CNT_W'(ret_slots));
      if (backend_stall) backend_cnt <= sat_add(backend_cnt, CNT_W'(dec_slots));
      else               bubble_cnt  <= sat_add(bubble_cnt, CNT_W'(DEC_FULL - dec_slots));
      flush_cnt <= sat_add(flush_cnt, CNT_W'(flush_pipe));
    end
  end

  // Snapshot FSM: capture shadows (p0), derive metrics in CALC, hold until ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      snap_vld    <= 1'b0;
      total_p0    <= '0;
      instr_p0    <= '0;
      retire_p0   <= '0;
      bubble_p0   <= '0;
      backend_p0  <= '0;
      flush_p0    <= '0;
      m_total     <= '0;
      m_retire    <= '0;
      m_bad_spec  <= '0;
      m_flush_rec <= '0;
      m_frontend  <= '0;
      m_backend   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (snap_req) begin
            total_p0   <= total_cnt;
            instr_p0   <= instr_cnt;
            retire_p0  <= retire_cnt;
            bubble_p0  <= bubble_cnt;
            backend_p0 <= backend_cnt;
            flush_p0   <= flush_cnt;
            state      <= S_CALC;
          end
        end
        S_CALC: begin
          m_total     <= total_p0;
          m_retire    <= retire_p0;
          m_backend   <= backend_p0;
          m_flush_rec <= flush_rec_calc;
          m_frontend  <= floor_sub(bubble_p0, flush_rec_calc);
          m_bad_spec  <= floor_sub(instr_p0, retire_p0);
          snap_vld    <= 1'b1;
          state       <= S_VALID;
        end
        S_VALID: begin
          if (snap_ack) begin
            snap_vld <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          snap_vld <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kiwi_tma_perf_counter.sv
// Self-checking bench for kiwi_tma_perf_counter (narrow counters so that
// saturation is reachable). A behavioural model keeps unbounded true sums and
// derives the metrics from them; a negedge process compares every cycle.
module tb_kiwi_tma_perf_counter;
  localparam int DW = 2;
  localparam int RW = 2;
  localparam int CW = 8;
  localparam int FP = 8;
  localparam logic [31:0] HALT = 32'h0000_006b;
  localparam longint MAXV = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_en = 1'b0, clear = 1'b0, backend_stall = 1'b0, flush_pipe = 1'b0;
  logic snap_req = 1'b0, snap_ack = 1'b0;
  logic [DW-1:0] decode_vld = '0;
  logic [32*DW-1:0] decode_inst = '0;
  logic [RW-1:0] retire_vld = '0;
  logic snap_vld, halted;
  logic [CW-1:0] m_total, m_retire, m_bad_spec, m_flush_rec, m_frontend, m_backend;

  int checks = 0;
  int errors = 0;

  kiwi_tma_perf_counter #(
    .DECODE_W(DW), .RETIRE_W(RW), .CNT_W(CW), .FLUSH_PENALTY(FP), .HALT_INST(HALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .clear(clear),
    .decode_vld(decode_vld), .decode_inst(decode_inst),
    .backend_stall(backend_stall), .flush_pipe(flush_pipe),
    .retire_vld(retire_vld), .snap_req(snap_req), .snap_ack(snap_ack),
    .snap_vld(snap_vld), .m_total(m_total), .m_retire(m_retire),
    .m_bad_spec(m_bad_spec), .m_flush_rec(m_flush_rec),
    .m_frontend(m_frontend), .m_backend(m_backend), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  // ---------------- behavioural model ----------------
  // True (unbounded) sums; saturation is applied only when read.
  longint s_total, s_instr, s_retire, s_bubble, s_backend, s_flush;
  bit     md_halted, md_busy, md_calc, md_vld;
  longint md_pend[6];   // total, retire, bad_spec, flush_rec, frontend, backend
  longint md_m[6];

  initial begin
    s_total = 0; s_instr = 0; s_retire = 0; s_bubble = 0; s_backend = 0; s_flush = 0;
    md_halted = 0; md_busy = 0; md_calc = 0; md_vld = 0;
    for (int i = 0; i < 6; i++) begin md_pend[i] = 0; md_m[i] = 0; end
  end

  always @(posedge clk) begin
    int nd, nr;
    longint t, in, r, b, bk, fr;
    if (!rst_n) begin
      s_total = 0; s_instr = 0; s_retire = 0; s_bubble = 0; s_backend = 0; s_flush = 0;
      md_halted = 0; md_busy = 0; md_calc = 0; md_vld = 0;
      for (int i = 0; i < 6; i++) md_m[i] = 0;
    end else begin
      // snapshot handshake, using counter values from before this edge
      if (md_vld) begin
        if (snap_ack) begin md_vld = 0; md_busy = 0; end
      end else if (md_calc) begin
        md_m = md_pend; md_calc = 0; md_vld = 1;
      end else if (!md_busy && snap_req) begin
        t = sat(s_total); in = sat(s_instr); r = sat(s_retire);
        b = sat(s_bubble); bk = sat(s_backend);
        fr = sat(sat(s_flush) * FP);
        md_pend[0] = t;
        md_pend[1] = r;
        md_pend[2] = (in > r) ? in - r : 0;
        md_pend[3] = fr;
        md_pend[4] = (b > fr) ? b - fr : 0;
        md_pend[5] = bk;
        md_busy = 1; md_calc = 1;
      end
      // raw counting
      nd = 0; nr = 0;
      for (int i = 0; i < DW; i++) nd += int'(decode_vld[i]);
      for (int i = 0; i < RW; i++) nr += int'(retire_vld[i]);
      if (clear) begin
        s_total = 0; s_instr = 0; s_retire = 0; s_bubble = 0; s_backend = 0; s_flush = 0;
      end else if (cnt_en && !md_halted) begin
        s_total  += DW;
        s_instr  += nd;
        s_retire += nr;
        if (backend_stall) s_backend += nd;
        else               s_bubble  += DW - nd;
        s_flush  += int'(flush_pipe);
      end
`ifdef KIWI_TMA_HALT_DETECT_EN
      for (int i = 0; i < DW; i++)
        if (decode_vld[i] && decode_inst[32*i +: 32] == HALT) md_halted = 1;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("snap_vld",    longint'(snap_vld),    longint'(md_vld));
    chk("halted",      longint'(halted),      longint'(md_halted));
    chk("m_total",     longint'(m_total),     md_m[0]);
    chk("m_retire",    longint'(m_retire),    md_m[1]);
    chk("m_bad_spec",  longint'(m_bad_spec),  md_m[2]);
    chk("m_flush_rec", longint'(m_flush_rec), md_m[3]);
    chk("m_frontend",  longint'(m_frontend),  md_m[4]);
    chk("m_backend",   longint'(m_backend),   md_m[5]);
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    cnt_en = 0; clear = 0; backend_stall = 0; flush_pipe = 0;
    snap_req = 0; snap_ack = 0; decode_vld = '0; decode_inst = '0; retire_vld = '0;
  endtask

  task automatic wait_vld(input string name);
    int n;
    n = 0;
    while (!snap_vld && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!snap_vld) begin
      errors++;
      $display("FAIL %s_wait: snap_vld stayed 0 for %0d cycles, required 1", name, n);
    end
  endtask

  task automatic take_snapshot(input string name);
    quiet();
    snap_req = 1;
    @(negedge clk);
    snap_req = 0;
    chk({name, "_calc_vld"}, longint'(snap_vld), 0);
    wait_vld(name);
  endtask

  task automatic ack_snapshot();
    snap_ack = 1;
    @(negedge clk);
    snap_ack = 0;
    chk("ack_drop", longint'(snap_vld), 0);
  endtask

  task automatic do_clear();
    quiet();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  logic [CW-1:0] held;

  initial begin
    quiet();
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_vld", longint'(snap_vld), 0);
    chk("rst_halted", longint'(halted), 0);
    chk("rst_total", longint'(m_total), 0);
    chk("rst_frontend", longint'(m_frontend), 0);
    rst_n = 1;

    // frontend-bound pattern
    cnt_en = 1; decode_vld = 2'b01; retire_vld = 2'b01;
    repeat (10) @(negedge clk);
    take_snapshot("fe");
    chk("fe_total", longint'(m_total), 20);
    chk("fe_retire", longint'(m_retire), 10);
    chk("fe_bad_spec", longint'(m_bad_spec), 0);
    chk("fe_frontend", longint'(m_frontend), 10);
    chk("fe_backend", longint'(m_backend), 0);
    chk("fe_flush_rec", longint'(m_flush_rec), 0);
    ack_snapshot();

    // backend stall then flush: frontend floored at 0
    do_clear();
    cnt_en = 1; decode_vld = 2'b11; backend_stall = 1;
    repeat (4) @(negedge clk);
    decode_vld = 2'b00; backend_stall = 0; flush_pipe = 1;
    repeat (2) @(negedge clk);
    take_snapshot("be");
    chk("be_total", longint'(m_total), 12);
    chk("be_backend", longint'(m_backend), 8);
    chk("be_flush_rec", longint'(m_flush_rec), 16);
    chk("be_frontend", longint'(m_frontend), 0);
    chk("be_bad_spec", longint'(m_bad_spec), 8);
    ack_snapshot();

    // saturation of total/retire
    do_clear();
    cnt_en = 1; decode_vld = 2'b11; retire_vld = 2'b11;
    repeat (130) @(negedge clk);
    take_snapshot("sat");
    chk("sat_total", longint'(m_total), 255);
    chk("sat_retire", longint'(m_retire), 255);
    ack_snapshot();

    // flush penalty product saturates; then hold VALID while counting
    do_clear();
    cnt_en = 1; flush_pipe = 1;
    repeat (32) @(negedge clk);
    take_snapshot("fl");
    chk("fl_flush_rec", longint'(m_flush_rec), 255);
    chk("fl_frontend", longint'(m_frontend), 0);
    held = m_total;
    cnt_en = 1;
    for (int i = 0; i < 5; i++) begin
      decode_vld = DW'($urandom); retire_vld = RW'($urandom);
      flush_pipe = 1'($urandom); snap_req = 1'($urandom);
      @(negedge clk);
    end
    quiet();
    chk("hold_vld", longint'(snap_vld), 1);
    chk("hold_total", longint'(m_total), longint'(held));
    chk("hold_flush_rec", longint'(m_flush_rec), 255);
    ack_snapshot();

    // halt detection (slot 1)
    do_clear();
    cnt_en = 1; decode_vld = 2'b10; decode_inst = {HALT, 32'h0000_0013};
    @(negedge clk);
    decode_inst = '0; decode_vld = 2'b11;
`ifdef KIWI_TMA_HALT_DETECT_EN
    chk("halt_set", longint'(halted), 1);
`else
    chk("halt_set", longint'(halted), 0);
`endif
    repeat (5) @(negedge clk);
    take_snapshot("halt");
`ifdef KIWI_TMA_HALT_DETECT_EN
    chk("halt_total", longint'(m_total), 2);
`else
    chk("halt_total", longint'(m_total), 12);
`endif
    ack_snapshot();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      clear         = ($urandom_range(0, 39) == 0);
      cnt_en        = ($urandom_range(0, 7) != 0);
      decode_vld    = DW'($urandom);
      retire_vld    = RW'($urandom);
      backend_stall = 1'($urandom);
      flush_pipe    = ($urandom_range(0, 3) == 0);
      snap_req      = ($urandom_range(0, 3) == 0);
      snap_ack      = ($urandom_range(0, 2) == 0);
      for (int s = 0; s < DW; s++)
        decode_inst[32*s +: 32] = ($urandom_range(0, 199) == 0) ? HALT : $urandom;
      @(negedge clk);
    end
    quiet();
    rst_n = 1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kiwi_tma_perf_counter.md
# kiwi_tma_perf_counter

Synthesizable top-down microarchitecture analysis (TMA) counter block for the kiwi core. It sits beside the CPU inside the subsystem and takes per-slot decode-valid, backend-stall, flush and retire strobes for a parametrised decode/retire width. It accumulates raw slot counts and, on request, produces a consistent snapshot of derived TMA metrics through a valid/ack handshake. Optionally, it detects the halt instruction and freezes itself.

## Interface
Parameters:
- DECODE_W, 2, decode slots per cycle (1..8)
- RETIRE_W, 2, retire slots per cycle (1..8)
- CNT_W, 64, width of every counter and metric output
- FLUSH_PENALTY, 8, slots charged per flush cycle
- HALT_INST, 32'h0000_006b, halt encoding matched when the halt-detect feature is compiled in

Ports:
- clk  in  1  core clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cnt_en  in  1  counting enable
- clear  in  1  zero all raw counters
- decode_vld  in  DECODE_W  per-slot decode valid
- decode_inst  in  32*DECODE_W  per-slot instruction; slot i is [32i+31:32i]
- backend_stall  in  1  backend cannot accept decode this cycle
- flush_pipe  in  1  pipeline flush this cycle
- retire_vld  in  RETIRE_W  per-slot retire
- snap_req  in  1  snapshot request
- snap_ack  in  1  consumer accepts the snapshot
- snap_vld  out  1  snapshot metrics valid
- m_total, m_retire, m_bad_spec, m_flush_rec, m_frontend, m_backend  out  CNT_W each  snapshot metrics
- halted  out  1  halt seen; counters frozen

## Operation
- Raw counters: total, instr, retire, bubble, backend, flush_cyc. Each is CNT_W wide and saturates at all-ones. None of them wraps.
- Per update cycle (cnt_en=1, halted=0, clear=0):
  - total += DECODE_W
  - instr += popcount(decode_vld)
  - retire += popcount(retire_vld)
  - If backend_stall: backend += popcount(decode_vld). Else: bubble += DECODE_W − popcount(decode_vld).
  - flush_cyc += flush_pipe
- Popcount width is $clog2(W+1). Increments are zero-extended to CNT_W before the saturating add.
- clear has priority over increment: all raw counters become 0 at that edge. clear does not affect the snapshot FSM, the snapshot registers, or halted.
- Snapshot FSM states:
  - IDLE: snap_req=1 captures the current registered raw values (excluding this edge's increment) into shadow registers, then goes to CALC.
  - CALC: one cycle.
    - m_flush_rec = flush_cyc*FLUSH_PENALTY, saturating
    - m_frontend = bubble − m_flush_rec, floored at 0
    - m_bad_spec = instr − retire, floored at 0
    - m_total, m_retire and m_backend are copied from the shadows
    - Goes to VALID.
  - VALID: snap_vld=1 and metrics are held stable. snap_ack=1 returns the FSM to IDLE at that edge.
- snap_req outside IDLE is ignored. Raw counting continues throughout CALC and VALID.

## Timing
- All outputs are 0 after reset, and the FSM is in IDLE.
- Counter update: a strobe in cycle N is visible in the raw registers at N+1.
- snap_req sampled high at edge N gives snap_vld=1 from edge N+2. That is 2 cycles of latency.
- snap_ack with snap_vld=1 at edge M gives snap_vld=0 at M+1. A new snap_req at M+1 gives snap_vld at M+3.
- snap_ack while snap_vld=0 is ignored.
- rst_n low at any edge returns everything to reset values regardless of FSM state, including mid-snapshot.
- Simultaneous snap_req and clear in IDLE: the snapshot captures the pre-clear values.

## Configuration
- KIWI_TMA_HALT_DETECT_EN defined:
  - A decode slot with decode_vld[i]=1 and decode_inst slot i == HALT_INST sets halted=1 at the next edge.
  - The cycle that contains the halt is still counted.
  - Afterwards, all raw counters freeze and only rst_n clears halted. The snapshot FSM keeps working.
- Not defined: halted is tied to 0, and decode_inst is unused.

## Test plan
- Reset with all inputs 0 for 3 cycles → every output 0, snap_vld=0.
- DECODE_W=2, 10 cycles of decode_vld=2'b01, no stall, retire_vld=2'b01, then snap_req → snap_vld 2 cycles later:
  - m_total=20, m_retire=10, m_bad_spec=0, m_frontend=10, m_backend=0.
- 4 cycles of decode_vld=2'b11 with backend_stall=1, then 2 cycles with flush_pipe=1 and decode_vld=0, retire 0 → m_backend=8, m_flush_rec=16, m_frontend=0 (floored from 4−16), m_bad_spec=8.
- CNT_W=8, preload near saturation by running 130 cycles of full decode → total stays at 255 and does not wrap.
- Hold snap_ack=0 for 5 cycles in VALID while counting continues → metrics stable. Then pulse snap_ack → snap_vld falls the next cycle.
- Halt-detect build: slot1 carries 32'h0000_006b with valid → halted=1 the next cycle, and later strobes leave the counters unchanged. Non-halt build: same stimulus leaves halted=0.
